// File: rtl/leglite_pkg.sv
// rtl/leglite_pkg.sv - shared widths, constants and state encoding for the LEGLite fetch path
package leglite_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] PC_STEP = 16'd2;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  // Word offset to byte displacement; the top offset bit falls off the 16-bit result.
  function automatic logic [WORD_W-1:0] branch_disp(input logic [WORD_W-1:0] offset);
    return {offset[WORD_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/leglite_pc_next.sv
// rtl/leglite_pc_next.sv - combinational next-PC adder: sequential step or taken-branch target
module leglite_pc_next
  import leglite_pkg::*;
(
  input  logic [WORD_W-1:0] inst_pc,
  input  logic [WORD_W-1:0] signext,
  input  logic              take,
  output logic [WORD_W-1:0] target
);

  logic [WORD_W-1:0] step;

  always_comb begin
    step   = take ? branch_disp(signext) : PC_STEP;
    target = inst_pc + step;
  end

endmodule

// File: rtl/leglite_fetch_ctrl.sv
// rtl/leglite_fetch_ctrl.sv - handshake-driven fetch/issue sequencer owning pc, instruction register and retire count
module leglite_fetch_ctrl
  import leglite_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic        inst_valid,
  input  logic        exec_done,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic [15:0] signext,
  output logic [15:0] pc,
  output logic [15:0] retired
);

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        complete;
  logic        take;
  logic [15:0] pc_target;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RST;
    end else begin
      state <= state_next;
    end
  end

  // accept/complete are the only qualified views of the handshakes; raw inputs
  // arriving in the wrong state never reach the datapath.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      ST_RST: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          accept     = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (exec_done) begin
          complete   = 1'b1;
          state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_RST;
      end
    endcase
  end

  assign imem_req   = (state == ST_FETCH);
  assign inst_valid = (state == ST_ISSUE);
  assign imem_addr  = pc;
  assign take       = branch & alu_zero;

  leglite_pc_next u_pc_next (
    .inst_pc (inst_pc),
    .signext (signext),
    .take    (take),
    .target  (pc_target)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pc      <= PC_RESET;
      inst    <= 16'h0000;
      inst_pc <= 16'h0000;
      retired <= 16'h0000;
    end else begin
      if (accept) begin
        inst    <= imem_rdata;
        inst_pc <= pc;
      end
      if (complete) begin
        pc      <= pc_target;
        retired <= retired + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_leglite_fetch_ctrl.sv
// tb/tb_leglite_fetch_ctrl.sv - self-checking bench for leglite_fetch_ctrl against an arithmetic reference model
module tb_leglite_fetch_ctrl;

  localparam logic [15:0] PC_RST = 16'h0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        exec_done;
  logic        branch;
  logic        alu_zero;
  logic [15:0] signext;
  logic [15:0] pc;
  logic [15:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_pc;
  logic [15:0] m_retired;

  leglite_fetch_ctrl #(.PC_RESET(PC_RST)) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .exec_done  (exec_done),
    .branch     (branch),
    .alu_zero   (alu_zero),
    .signext    (signext),
    .pc         (pc),
    .retired    (retired)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_next(input logic [15:0] ipc, input bit taken, input logic [15:0] off);
    int unsigned t;
    t = taken ? (32'(ipc) + 32'(off) * 2) : (32'(ipc) + 2);
    return 16'(t % 65536);
  endfunction

  // Drives one complete fetch/execute; returns what was seen so callers can compare.
  task automatic exec_inst(input int ack_wait, input int done_wait, input logic [15:0] rdata,
                           input bit br, input bit az, input logic [15:0] se,
                           output logic [15:0] addr_seen, output logic [15:0] inst_seen,
                           output logic [15:0] ipc_seen, output bit ok);
    int guard;
    guard = 0;
    ok = 1'b1;
    while (imem_req !== 1'b1 && guard < 8) begin
      @(negedge clock);
      guard++;
    end
    if (imem_req !== 1'b1) ok = 1'b0;
    addr_seen = imem_addr;
    repeat (ack_wait) @(negedge clock);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    @(negedge clock);
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    if (inst_valid !== 1'b1) ok = 1'b0;
    inst_seen = inst;
    ipc_seen  = inst_pc;
    repeat (done_wait) @(negedge clock);
    exec_done = 1'b1;
    branch    = br;
    alu_zero  = az;
    signext   = se;
    @(negedge clock);
    exec_done = 1'b0;
    branch    = 1'($urandom);
    alu_zero  = 1'($urandom);
    signext   = 16'($urandom);
    m_pc      = ref_next(m_pc, br && az, se);
    m_retired = m_retired + 16'd1;
    if (imem_req !== 1'b1 || inst_valid !== 1'b0) ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0; exec_done = 1'b0;
    branch = 1'b0; alu_zero = 1'b0; signext = 16'h0;
    repeat (3) @(negedge clock);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    n_checks++; if (pc !== PC_RST) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, PC_RST); end
    n_checks++; if (retired !== 16'h0) begin n_fail++; $display("FAIL reset_retired: got %h expected 0000", retired); end
    n_checks++; if (inst !== 16'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0000", inst); end
    n_checks++; if (inst_pc !== 16'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h expected 0000", inst_pc); end
    reset = 1'b0;
    m_pc = PC_RST;
    m_retired = 16'h0;
    @(negedge clock);
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_exit_req: got %b expected 1", imem_req); end
    n_checks++; if (imem_addr !== PC_RST) begin n_fail++; $display("FAIL reset_exit_addr: got %h expected %h", imem_addr, PC_RST); end
  endtask

  task automatic test_basic();
    logic [15:0] a, in, ip, d, exp_a;
    bit ok;
    time t_prev;
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom);
      exp_a = 16'(2 * i);
      exec_inst(0, 0, d, 1'b0, 1'b0, 16'h0, a, in, ip, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_handshake[%0d]: got bad handshake expected clean", i); end
      n_checks++; if (a !== exp_a) begin n_fail++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, a, exp_a); end
      n_checks++; if (in !== d) begin n_fail++; $display("FAIL basic_inst[%0d]: got %h expected %h", i, in, d); end
      n_checks++; if (ip !== exp_a) begin n_fail++; $display("FAIL basic_inst_pc[%0d]: got %h expected %h", i, ip, exp_a); end
    end
    n_checks++; if (retired !== 16'd3) begin n_fail++; $display("FAIL basic_retired: got %0d expected 3", retired); end
    n_checks++; if (imem_addr !== 16'h0006) begin n_fail++; $display("FAIL basic_next_addr: got %h expected 0006", imem_addr); end
    // Best case: a new fetch every 2 cycles.
    for (int i = 0; i < 2; i++) begin
      t_prev = $time;
      exec_inst(0, 0, 16'($urandom), 1'b0, 1'b0, 16'h0, a, in, ip, ok);
      n_checks++; if ($time - t_prev != 20) begin n_fail++; $display("FAIL basic_cadence[%0d]: got %0t expected 20", i, $time - t_prev); end
    end
  endtask

  task automatic test_stall();
    logic [15:0] a0, d;
    a0 = imem_addr;
    n_checks++; if (a0 !== m_pc) begin n_fail++; $display("FAIL stall_start_addr: got %h expected %h", a0, m_pc); end
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'b0;
      imem_rdata = 16'($urandom);
      @(negedge clock);
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_req[%0d]: got %b expected 1", i, imem_req); end
      n_checks++; if (imem_addr !== a0) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected %h", i, imem_addr, a0); end
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 0", i, inst_valid); end
    end
    d = 16'hA5C3;
    imem_ack = 1'b1; imem_rdata = d;
    @(negedge clock);
    imem_ack = 1'b0; imem_rdata = 16'h0;
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid_after_ack: got %b expected 1", inst_valid); end
    n_checks++; if (inst !== d) begin n_fail++; $display("FAIL stall_inst: got %h expected %h", inst, d); end
    exec_done = 1'b1; branch = 1'b0; alu_zero = 1'b0;
    @(negedge clock);
    exec_done = 1'b0;
    m_pc = ref_next(m_pc, 1'b0, 16'h0);
    m_retired = m_retired + 16'd1;
    n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL stall_pc: got %h expected %h", pc, m_pc); end
  endtask

  task automatic test_branch();
    logic [15:0] a, in, ip;
    bit ok;
    exec_inst(0, 0, 16'h1111, 1'b1, 1'b1, 16'((16'h0010 - m_pc) >> 1), a, in, ip, ok);
    n_checks++; if (imem_addr !== 16'h0010) begin n_fail++; $display("FAIL branch_reach: got %h expected 0010", imem_addr); end
    exec_inst(0, 1, 16'h2222, 1'b1, 1'b1, 16'hFFFC, a, in, ip, ok);
    n_checks++; if (ip !== 16'h0010) begin n_fail++; $display("FAIL branch_inst_pc: got %h expected 0010", ip); end
    n_checks++; if (imem_addr !== 16'h0008) begin n_fail++; $display("FAIL branch_taken: got %h expected 0008", imem_addr); end
    exec_inst(0, 0, 16'h3333, 1'b1, 1'b1, 16'h0004, a, in, ip, ok);
    n_checks++; if (imem_addr !== 16'h0010) begin n_fail++; $display("FAIL branch_fwd: got %h expected 0010", imem_addr); end
    exec_inst(1, 0, 16'h4444, 1'b1, 1'b0, 16'hFFFC, a, in, ip, ok);
    n_checks++; if (imem_addr !== 16'h0012) begin n_fail++; $display("FAIL branch_not_taken: got %h expected 0012", imem_addr); end
    exec_inst(0, 0, 16'h5555, 1'b1, 1'b1, 16'h0000, a, in, ip, ok);
    n_checks++; if (imem_addr !== 16'h0012) begin n_fail++; $display("FAIL branch_self_loop: got %h expected 0012", imem_addr); end
    n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL branch_model_pc: got %h expected %h", pc, m_pc); end
  endtask

  task automatic test_ignore();
    logic [15:0] p0, r0, d;
    p0 = m_pc;
    r0 = m_retired;
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b0;
      exec_done = 1'($urandom); branch = 1'($urandom); alu_zero = 1'($urandom); signext = 16'($urandom);
      if (i == 0) begin exec_done = 1'b1; branch = 1'b1; alu_zero = 1'b1; end
      @(negedge clock);
      n_checks++; if (imem_req !== 1'b1 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL ignore_fetch_state[%0d]: got req=%b valid=%b expected req=1 valid=0", i, imem_req, inst_valid); end
      n_checks++; if (pc !== p0 || retired !== r0) begin n_fail++; $display("FAIL ignore_fetch_regs[%0d]: got pc=%h ret=%h expected pc=%h ret=%h", i, pc, retired, p0, r0); end
    end
    exec_done = 1'b0;
    d = 16'h6C39;
    imem_ack = 1'b1; imem_rdata = d;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; imem_rdata = ~d; exec_done = 1'b0;
      @(negedge clock);
      n_checks++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL ignore_issue_state[%0d]: got valid=%b req=%b expected valid=1 req=0", i, inst_valid, imem_req); end
      n_checks++; if (inst !== d || inst_pc !== p0 || pc !== p0) begin n_fail++; $display("FAIL ignore_issue_regs[%0d]: got inst=%h ipc=%h pc=%h expected inst=%h ipc=%h pc=%h", i, inst, inst_pc, pc, d, p0, p0); end
    end
    imem_ack = 1'b0;
    exec_done = 1'b1; branch = 1'b0; alu_zero = 1'b0;
    @(negedge clock);
    exec_done = 1'b0;
    m_pc = ref_next(m_pc, 1'b0, 16'h0);
    m_retired = m_retired + 16'd1;
    n_checks++; if (pc !== m_pc || retired !== m_retired) begin n_fail++; $display("FAIL ignore_complete: got pc=%h ret=%h expected pc=%h ret=%h", pc, retired, m_pc, m_retired); end
  endtask

  task automatic test_reset_midfetch();
    logic [15:0] a, in, ip;
    bit ok;
    exec_inst(0, 0, 16'h0F0F, 1'b0, 1'b0, 16'h0, a, in, ip, ok);
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    @(negedge clock);
    imem_ack = 1'b0;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b expected 0", imem_req); end
    n_checks++; if (pc !== PC_RST) begin n_fail++; $display("FAIL rstmid_pc: got %h expected %h", pc, PC_RST); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", inst_valid); end
    n_checks++; if (retired !== 16'h0) begin n_fail++; $display("FAIL rstmid_retired: got %h expected 0000", retired); end
    reset = 1'b0;
    m_pc = PC_RST;
    m_retired = 16'h0;
    @(negedge clock);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== PC_RST) begin n_fail++; $display("FAIL rstmid_resume: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, PC_RST); end
  endtask

  task automatic test_random();
    logic [15:0] a, in, ip, d, exp_a, se;
    bit ok, br, az;
    for (int i = 0; i < 40; i++) begin
      d = 16'($urandom);
      se = 16'($urandom);
      br = 1'($urandom);
      az = 1'($urandom);
      exp_a = m_pc;
      exec_inst(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d, br, az, se, a, in, ip, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_handshake[%0d]: got bad handshake expected clean", i); end
      n_checks++; if (a !== exp_a || ip !== exp_a) begin n_fail++; $display("FAIL rand_addr[%0d]: got addr=%h ipc=%h expected %h", i, a, ip, exp_a); end
      n_checks++; if (in !== d) begin n_fail++; $display("FAIL rand_inst[%0d]: got %h expected %h", i, in, d); end
      n_checks++; if (pc !== m_pc || imem_addr !== m_pc) begin n_fail++; $display("FAIL rand_pc[%0d]: got pc=%h addr=%h expected %h", i, pc, imem_addr, m_pc); end
      n_checks++; if (retired !== m_retired) begin n_fail++; $display("FAIL rand_retired[%0d]: got %h expected %h", i, retired, m_retired); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] a, in, ip;
    bit ok;
    force dut.retired = 16'hFFFE;
    #1;
    release dut.retired;
    m_retired = 16'hFFFE;
    exec_inst(0, 0, 16'h7777, 1'b0, 1'b0, 16'h0, a, in, ip, ok);
    n_checks++; if (retired !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got %h expected FFFF", retired); end
    exec_inst(0, 0, 16'h8888, 1'b0, 1'b0, 16'h0, a, in, ip, ok);
    n_checks++; if (retired !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0000", retired); end
    exec_inst(0, 0, 16'h9999, 1'b1, 1'b1, 16'((16'hFFFE - m_pc) >> 1), a, in, ip, ok);
    n_checks++; if (imem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_reach_top: got %h expected FFFE", imem_addr); end
    exec_inst(0, 0, 16'hAAAA, 1'b1, 1'b1, 16'h0002, a, in, ip, ok);
    n_checks++; if (imem_addr !== 16'h0002) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0002", imem_addr); end
    exec_inst(0, 0, 16'hBBBB, 1'b1, 1'b1, 16'hFFFF, a, in, ip, ok);
    n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_msb_drop: got %h expected 0000", pc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_branch();
    test_ignore();
    test_reset_midfetch();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/leglite_fetch_ctrl.md
# leglite_fetch_ctrl

Fetch/issue controller for the LEGLite multicycle core. Owns the program counter and sequences each instruction through an instruction-memory request/acknowledge handshake, then holds it for the execute stage until completion. At completion it applies the PC update: a taken CBZ jumps, anything else advances by 2. Sits between the instruction memory port and the decode/execute datapath, and replaces free-running PC increment with handshake-driven sequencing.

## Interface
Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  16  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  16  fetched instruction word.
- inst  out  16  instruction register presented to decode.
- inst_pc  out  16  PC of the instruction in inst.
- inst_valid  out  1  inst is valid and awaiting execution.
- exec_done  in  1  execute stage finished the current instruction.
- branch  in  1  current instruction is CBZ; sampled only with exec_done.
- alu_zero  in  1  ALU zero flag; sampled only with exec_done.
- signext  in  16  sign-extended branch offset in words; sampled only with exec_done.
- pc  out  16  current program counter.
- retired  out  16  count of completed instructions.

## Operation
- States: RST, FETCH, ISSUE.
- RST:
  - Entered on any cycle with reset=1, from any state.
  - pc=PC_RESET, inst=0, inst_pc=0, inst_valid=0, imem_req=0, retired=0.
  - The first cycle after reset deasserts moves to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1: inst<=imem_rdata, inst_pc<=pc, go to ISSUE.
  - Otherwise stay in FETCH; addr and req held stable. Waiting is unbounded.
- ISSUE:
  - inst_valid=1, imem_req=0.
  - On exec_done=1, go to FETCH and update pc:
    - branch=1 and alu_zero=1: pc <= inst_pc + (signext<<1).
    - else: pc <= inst_pc + 2.
  - On the same exec_done cycle, retired<=retired+1.
- Arithmetic is modulo 2^16.
  - The shift drops signext[15]; result truncated to 16 bits.
  - pc bit 0 stays 0 provided PC_RESET is even.
  - retired wraps FFFF->0000.
- Inputs outside their valid state are ignored:
  - imem_ack outside FETCH.
  - exec_done, branch, alu_zero and signext outside ISSUE.
- inst holds its value outside ISSUE; only inst_valid qualifies it.

## Timing
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- Best case is 2 cycles per instruction: ack in the first FETCH cycle, exec_done in the first ISSUE cycle.
- Latencies:
  - imem_req is asserted 1 cycle after reset deasserts.
  - inst_valid rises 1 cycle after the ack cycle.
  - The new pc and imem_req=1 appear 1 cycle after the exec_done cycle.
- reset has priority over every other input, including imem_ack and exec_done in the same cycle.
  - Reset mid-fetch drops req immediately (next edge). No recovery of the outstanding request; memory must tolerate an abandoned req.
  - A retired increment coincident with reset is lost.
- A taken branch to its own PC (signext=0) loops legally.

## Structure
- Shared package (leglite_pkg):
  - State encoding constants for RST/FETCH/ISSUE.
  - WORD_W=16.
  - PC_STEP=2.
- Sub-module leglite_pc_next: combinational next-PC adder (inst_pc, signext, take) -> 16-bit target. Reusable by a later pipelined core.
- The FSM, instruction register and retired counter stay in the top block.

## Test plan
- Reset, then ack every fetch immediately and exec_done immediately:
  - imem_addr sequence 0000, 0002, 0004 on every other cycle.
  - retired=3 after 3 instructions.
- Hold imem_ack=0 for 5 cycles in FETCH:
  - imem_req=1 and imem_addr constant throughout.
  - inst_valid=0 throughout.
  - The ack on cycle 6 loads inst=imem_rdata.
- Taken branch at inst_pc=0x0010 with signext=0xFFFC, branch=1, alu_zero=1 → next imem_addr=0x0008.
  - Same inputs with alu_zero=0 → 0x0012.
- Toggle branch, alu_zero and exec_done while in FETCH, and imem_ack while in ISSUE → no state, pc or retired change.
- Assert reset during FETCH with imem_ack=1 in the same cycle:
  - Next cycle imem_req=0, pc=PC_RESET, inst_valid=0.
  - FETCH resumes 1 cycle after reset falls.
- Preload via 65535 retirements (or force) → retired wraps FFFF→0000.
  - Branch from 0xFFFE with +2 offset → pc 0x0002.
